// File: rtl/rice_pkg.sv
// Shared definitions for the Rice encoder and its matching decoder.
package rice_pkg;
  localparam int DATA_W  = 16;
  localparam int PARAM_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UNARY = 2'd1,
    STOP  = 2'd2,
    REM   = 2'd3
  } rice_state_t;
endpackage

// File: rtl/rice_fold.sv
// Zig-zag fold of a signed residual followed by the Rice quotient/remainder split.
module rice_fold #(
  parameter int DATA_W  = rice_pkg::DATA_W,
  parameter int PARAM_W = rice_pkg::PARAM_W
) (
  input  logic signed [DATA_W-1:0]  x_i,
  input  logic        [PARAM_W-1:0] k_i,
  output logic        [DATA_W-1:0]  q_o,
  output logic        [DATA_W-1:0]  r_o
);
  logic [DATA_W-1:0] u;
  logic [DATA_W-1:0] mask;

  // -2x-1 equals ~(2x), so a sign-controlled inversion of 2x covers both halves
  assign u    = {x_i[DATA_W-2:0], 1'b0} ^ {DATA_W{x_i[DATA_W-1]}};
  assign mask = ~({DATA_W{1'b1}} << k_i);
  assign q_o  = u >> k_i;
  assign r_o  = u & mask;
endmodule

// File: rtl/rice_encoder.sv
// Serial Rice encoder: q zeros, a stop 1, then k remainder bits MSB first.
module rice_encoder #(
  parameter int DATA_W  = rice_pkg::DATA_W,
  parameter int PARAM_W = rice_pkg::PARAM_W
) (
  input  logic                      iClock,
  input  logic                      iReset,
  input  logic                      iEnable,
  input  logic                      iValid,
  input  logic signed [DATA_W-1:0]  iData,
  input  logic        [PARAM_W-1:0] iRiceParam,
  output logic                      oReady,
  output logic                      oBit,
  output logic                      oBitValid,
  output logic                      oDone
);
  import rice_pkg::*;

  rice_state_t        state_q;
  logic [DATA_W-1:0]  cnt_q;
  logic [DATA_W-1:0]  r_q;
  logic [PARAM_W-1:0] k_q;
  logic [PARAM_W-1:0] idx_q;
  logic               bit_q;
  logic               last_q;

  logic [DATA_W-1:0]  fold_q;
  logic [DATA_W-1:0]  fold_r;
  logic [PARAM_W-1:0] k_dec;
  logic [PARAM_W-1:0] idx_dec;
  logic               advance;

  rice_fold #(
    .DATA_W (DATA_W),
    .PARAM_W(PARAM_W)
  ) u_fold (
    .x_i(iData),
    .k_i(iRiceParam),
    .q_o(fold_q),
    .r_o(fold_r)
  );

  assign k_dec     = k_q - 1'b1;
  assign idx_dec   = idx_q - 1'b1;
  assign oReady    = (state_q == IDLE);
  assign advance   = (state_q != IDLE) && iEnable;
  assign oBitValid = advance;
  assign oBit      = bit_q;
  assign oDone     = advance && last_q;

  // Codeword sequencer; bit_q/last_q always describe the bit of the current state
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      k_q     <= '0;
      idx_q   <= '0;
      bit_q   <= 1'b0;
      last_q  <= 1'b0;
    end else if (state_q == IDLE) begin
      if (iValid) begin
        r_q   <= fold_r;
        k_q   <= iRiceParam;
        cnt_q <= fold_q;
        if (|fold_q) begin
          state_q <= UNARY;
          bit_q   <= 1'b0;
          last_q  <= 1'b0;
        end else begin
          state_q <= STOP;
          bit_q   <= 1'b1;
          last_q  <= (iRiceParam == '0);
        end
      end
    end else if (advance) begin
      case (state_q)
        UNARY: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == DATA_W'(1)) begin
            state_q <= STOP;
            bit_q   <= 1'b1;
            last_q  <= (k_q == '0);
          end else begin
            bit_q  <= 1'b0;
            last_q <= 1'b0;
          end
        end
        STOP: begin
          if (k_q != '0) begin
            state_q <= REM;
            idx_q   <= k_dec;
            bit_q   <= r_q[k_dec];
            last_q  <= (k_q == PARAM_W'(1));
          end else begin
            state_q <= IDLE;
            bit_q   <= 1'b0;
            last_q  <= 1'b0;
          end
        end
        REM: begin
          if (idx_q == '0) begin
            state_q <= IDLE;
            bit_q   <= 1'b0;
            last_q  <= 1'b0;
          end else begin
            idx_q  <= idx_dec;
            bit_q  <= r_q[idx_dec];
            last_q <= (idx_q == PARAM_W'(1));
          end
        end
        default: begin
          state_q <= IDLE;
          bit_q   <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rice_encoder.sv
// Directed and loopback bench for rice_encoder.
module tb_rice_encoder;
  logic               iClock = 1'b0;
  logic               iReset;
  logic               iEnable;
  logic               iValid;
  logic signed [15:0] iData;
  logic        [3:0]  iRiceParam;
  logic               oReady;
  logic               oBit;
  logic               oBitValid;
  logic               oDone;

  int checks = 0;
  int errors = 0;

  rice_encoder dut (
    .iClock    (iClock),
    .iReset    (iReset),
    .iEnable   (iEnable),
    .iValid    (iValid),
    .iData     (iData),
    .iRiceParam(iRiceParam),
    .oReady    (oReady),
    .oBit      (oBit),
    .oBitValid (oBitValid),
    .oDone     (oDone)
  );

  always #5 iClock = ~iClock;

  typedef struct {
    logic signed [15:0] x;
    logic        [3:0]  k;
    int                 len;
    logic        [63:0] pat;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Entered and left just after a rising edge with the DUT idle.
  task automatic send(input logic signed [15:0] x, input logic [3:0] k, input int len,
                      input logic [63:0] pat, input int stall_at, input int stall_n,
                      input logic noise);
    logic held;
    held = 1'b0;
    iValid = 1'b1; iData = x; iRiceParam = k; iEnable = 1'b1;
    @(negedge iClock);
    chk("ready_before_accept", int'(oReady), 1);
    @(posedge iClock); #1;
    iValid = noise; iData = 16'sh5a5a; iRiceParam = 4'hf;
    for (int i = 0; i < len; i++) begin
      @(negedge iClock);
      chk("bit_valid", int'(oBitValid), 1);
      chk("bit_value", int'(oBit), int'(pat[len-1-i]));
      chk("done_flag", int'(oDone), (i == len-1) ? 1 : 0);
      chk("ready_busy", int'(oReady), 0);
      @(posedge iClock); #1;
      iValid = (i < len-2) ? noise : 1'b0;
      if (i == stall_at) begin
        iEnable = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge iClock);
          chk("stall_valid", int'(oBitValid), 0);
          chk("stall_done", int'(oDone), 0);
          if (s > 0) chk("stall_bit_hold", int'(oBit), int'(held));
          held = oBit;
          @(posedge iClock); #1;
        end
        iEnable = 1'b1;
      end
    end
    @(negedge iClock);
    chk("ready_after", int'(oReady), 1);
    chk("valid_after", int'(oBitValid), 0);
    chk("done_after", int'(oDone), 0);
    @(posedge iClock); #1;
  endtask

  initial begin
    int k, lim, x, zeros, rb, cyc, u, dec;
    logic got_stop, finished, done_bad;
    logic [31:0] r;

    tbl[0] = '{-16'sd23,    4'd3,  9,  64'b000001101};
    tbl[1] = '{16'sd0,      4'd0,  1,  64'b1};
    tbl[2] = '{16'sh8000,   4'd15, 17, 64'b01_111111111111111};
    tbl[3] = '{16'sd3,      4'd2,  4,  64'b0110};
    tbl[4] = '{16'sd1,      4'd0,  3,  64'b001};
    tbl[5] = '{-16'sd1,     4'd1,  2,  64'b11};
    tbl[6] = '{16'sd5,      4'd4,  5,  64'b11010};
    tbl[7] = '{16'sd32767,  4'd15, 17, 64'b01_111111111111110};
    tbl[8] = '{-16'sd4,     4'd2,  4,  64'b0111};
    tbl[9] = '{16'sd10,     4'd0,  21, 64'b000000000000000000001};

    iReset = 1'b1; iEnable = 1'b1; iValid = 1'b0; iData = '0; iRiceParam = '0;
    @(negedge iClock);
    chk("rst_ready", int'(oReady), 1);
    chk("rst_bit", int'(oBit), 0);
    chk("rst_valid", int'(oBitValid), 0);
    chk("rst_done", int'(oDone), 0);
    @(posedge iClock); #1;
    iReset = 1'b0;

    for (int v = 0; v < 10; v++)
      send(tbl[v].x, tbl[v].k, tbl[v].len, tbl[v].pat, -1, 0, v[0]);

    // Three-cycle stall after the 4th bit
    send(-16'sd23, 4'd3, 9, 64'b000001101, 3, 3, 1'b1);

    // Reset pulse after the 3rd bit abandons the codeword
    iValid = 1'b1; iData = -16'sd23; iRiceParam = 4'd3; iEnable = 1'b1;
    @(posedge iClock); #1;
    iValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge iClock);
      chk("pre_reset_bit", int'(oBit), 0);
      chk("pre_reset_valid", int'(oBitValid), 1);
      @(posedge iClock); #1;
    end
    iReset = 1'b1;
    @(negedge iClock);
    chk("mid_rst_ready", int'(oReady), 1);
    chk("mid_rst_valid", int'(oBitValid), 0);
    chk("mid_rst_done", int'(oDone), 0);
    chk("mid_rst_bit", int'(oBit), 0);
    @(posedge iClock); #1;
    iReset = 1'b0;
    send(16'sd0, 4'd0, 1, 64'b1, -1, 0, 1'b0);

    // Loopback through a bench-side decoder with random stalls
    for (int n = 0; n < 1000; n++) begin
      k = $urandom_range(0, 15);
      lim = (k >= 12) ? 32767 : ((8 << k) - 1);
      x = int'($urandom_range(0, 2*lim)) - lim;
      iValid = 1'b1; iData = x[15:0]; iRiceParam = k[3:0];
      @(posedge iClock); #1;
      iValid = 1'b0;
      zeros = 0; rb = 0; cyc = 0; r = '0;
      got_stop = 1'b0; finished = 1'b0; done_bad = 1'b0;
      while (!finished && cyc < 300) begin
        iEnable = ($urandom_range(0, 3) != 0);
        @(negedge iClock);
        cyc++;
        if (oBitValid) begin
          if (!got_stop) begin
            if (oBit) got_stop = 1'b1;
            else zeros++;
          end else begin
            r = {r[30:0], oBit};
            rb++;
          end
          finished = got_stop && (rb == k);
          if (oDone != finished) done_bad = 1'b1;
        end else if (oDone) begin
          done_bad = 1'b1;
        end
        @(posedge iClock); #1;
      end
      iEnable = 1'b1;
      if (!finished) begin
        chk("loop_timeout", 0, 1);
        @(posedge iClock); #1;
        iReset = 1'b1;
        @(posedge iClock); #1;
        iReset = 1'b0;
      end else begin
        u = (zeros << k) | int'(r);
        dec = u[0] ? -((u + 1) >>> 1) : (u >>> 1);
        chk("loop_value", dec, x);
        chk("loop_done", int'(done_bad), 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
